// File: rtl/ws2812_rgb_controller.sv
// WS2812 single-wire serialiser: shifts one GRB pixel out MSB first, or holds the
// line low for the strip latch period. All outputs come straight from flops.
module ws2812_rgb_controller #(
    parameter int unsigned T0H_CYCLES   = 4,
    parameter int unsigned T1H_CYCLES   = 8,
    parameter int unsigned BIT_CYCLES   = 13,
    parameter int unsigned LATCH_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    input  logic [1:0] cmd_i,
    output logic       cmd_req_o,
    output logic       data_out_o
);

    // One counter serves both the per-bit timing and the latch period.
    localparam int unsigned CntMax = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t BitLast   = cnt_t'(BIT_CYCLES - 1);
    localparam cnt_t LatchLast = cnt_t'(LATCH_CYCLES - 1);
    localparam cnt_t T0hCnt    = cnt_t'(T0H_CYCLES);
    localparam cnt_t T1hCnt    = cnt_t'(T1H_CYCLES);

    localparam logic [1:0] CmdSend  = 2'b01;
    localparam logic [1:0] CmdLatch = 2'b10;

    localparam logic [4:0] LastBit = 5'd23;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StLatch
    } state_e;

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] sr_q, sr_d;
    logic        data_out_q, data_out_d;
    logic        cmd_req_q, cmd_req_d;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            data_out_q <= 1'b0;
            cmd_req_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            cmd_req_q  <= cmd_req_d;
        end
    end

    // Next-state: command acceptance in idle, bit/cycle sequencing, latch timing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_i == CmdSend) begin
                    state_d = StSend;
                    sr_d    = {g_i, r_i, b_i};
                    cnt_d   = '0;
                    bit_d   = '0;
                end else if (cmd_i == CmdLatch) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_q == LastBit) begin
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 5'd1;
                        sr_d  = {sr_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from next-state values so the registered line lines up
    // with the cycle the counter describes (first high cycle right after acceptance).
    always_comb begin
        cmd_req_d  = (state_d == StIdle);
        data_out_d = (state_d == StSend) && (cnt_d < (sr_d[23] ? T1hCnt : T0hCnt));
    end

    assign cmd_req_o  = cmd_req_q;
    assign data_out_o = data_out_q;

endmodule

// File: tb/tb_ws2812_rgb_controller.sv
// Bench for ws2812_rgb_controller: pixels accepted on the handshake are queued as
// expected GRB words; a line monitor decodes data_out back into words and compares.
module tb_ws2812_rgb_controller;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] r_i   = '0;
    logic [7:0] g_i   = '0;
    logic [7:0] b_i   = '0;
    logic [1:0] cmd_i = '0;
    logic       cmd_req_o;
    logic       data_out_o;

    ws2812_rgb_controller dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .r_i        (r_i),
        .g_i        (g_i),
        .b_i        (b_i),
        .cmd_i      (cmd_i),
        .cmd_req_o  (cmd_req_o),
        .data_out_o (data_out_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected line shapes of one bit period (first sample in the MSB).
    localparam logic [12:0] Pat1 = 13'b1111111100000;
    localparam logic [12:0] Pat0 = 13'b1111000000000;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [23:0] sb[$];

    logic        mon_active   = 1'b0;
    int          mon_bit      = 0;
    int          mon_cyc      = 0;
    logic [12:0] mon_samp     = '0;
    logic [23:0] mon_word     = '0;
    logic        mon_req_bad  = 1'b0;
    int          mon_gap      = 0;
    int          mon_gap_last = 0;
    int          mon_starts   = 0;
    int          frames_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (sb.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Scoreboard push on acceptance and line decode, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
            mon_active = 1'b0;
            mon_gap    = 0;
        end else begin
            if (mon_active || data_out_o === 1'b1) begin
                if (!mon_active) begin
                    mon_active   = 1'b1;
                    mon_bit      = 0;
                    mon_cyc      = 0;
                    mon_word     = '0;
                    mon_req_bad  = 1'b0;
                    mon_gap_last = mon_gap;
                    mon_gap      = 0;
                    mon_starts++;
                end
                mon_samp = {mon_samp[11:0], data_out_o};
                if (cmd_req_o !== 1'b0) mon_req_bad = 1'b1;
                mon_cyc++;
                if (mon_cyc == 13) begin
                    check("bit_shape", 32'(mon_samp), 32'(mon_samp[8] ? Pat1 : Pat0));
                    mon_word = {mon_word[22:0], mon_samp[8]};
                    mon_cyc  = 0;
                    if (mon_bit == 23) begin
                        mon_active = 1'b0;
                        check("req_low_in_send", 32'(mon_req_bad), 32'd0);
                        if (sb.size() == 0) check("sb_underflow", sb.size(), 32'd1);
                        else check("frame", 32'(mon_word), 32'(sb.pop_front()));
                        frames_seen++;
                    end else begin
                        mon_bit++;
                    end
                end
            end else begin
                mon_gap++;
            end
            if (cmd_req_o === 1'b1 && cmd_i == 2'b01) sb.push_back({g_i, r_i, b_i});
        end
    end

    initial begin
        int f0, n_low, n_hi, first_hi, s0, seen;
        bit ok;

        // Reset, then idle with cmd=00.
        rst_i = 1'b1;
        tick();
        check("rst_data", 32'(data_out_o), 32'd0);
        check("rst_req", 32'(cmd_req_o), 32'd1);
        tick();
        rst_i = 1'b0;
        n_low = 0;
        n_hi  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_out_o !== 1'b0) n_hi++;
            if (cmd_req_o !== 1'b1) n_low++;
        end
        check("idle_data", 32'(n_hi), 32'd0);
        check("idle_req", 32'(n_low), 32'd0);
        check("idle_frames", 32'(frames_seen), 32'd0);

        // Single pixel, cmd held 50 cycles then dropped.
        f0 = frames_seen;
        r_i = 8'd255; g_i = 8'd0; b_i = 8'd128; cmd_i = 2'b01;
        n_low = 0;
        first_hi = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 49) cmd_i = 2'b00;
            if (cmd_req_o === 1'b0) n_low++;
            if (data_out_o === 1'b1 && first_hi < 0) first_hi = i;
        end
        check("px_len", 32'(n_low), 32'd312);
        check("px_first_hi", 32'(first_hi), 32'd0);
        check("px_count", 32'(frames_seen - f0), 32'd1);
        check("px_req_after", 32'(cmd_req_o), 32'd1);

        // Latch period.
        f0 = frames_seen;
        cmd_i = 2'b10;
        n_low = 0;
        n_hi  = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (i == 0) cmd_i = 2'b00;
            if (cmd_req_o === 1'b0) n_low++;
            if (data_out_o !== 1'b0) n_hi++;
        end
        check("latch_len", 32'(n_low), 32'd500);
        check("latch_data", 32'(n_hi), 32'd0);
        check("latch_req_after", 32'(cmd_req_o), 32'd1);
        check("latch_frames", 32'(frames_seen - f0), 32'd0);

        // Reserved command behaves as idle.
        f0 = frames_seen;
        cmd_i = 2'b11;
        n_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cmd_req_o !== 1'b1) n_low++;
        end
        cmd_i = 2'b00;
        check("cmd11_req", 32'(n_low), 32'd0);
        check("cmd11_frames", 32'(frames_seen - f0), 32'd0);

        // Streaming with cmd held at 01.
        f0 = frames_seen;
        g_i = 8'hAA; r_i = 8'h55; b_i = 8'hF0; cmd_i = 2'b01;
        s0   = mon_starts;
        seen = s0;
        ok   = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (mon_starts != seen) begin
                seen = mon_starts;
                if (seen > s0 + 1) check("stream_gap", 32'(mon_gap_last), 32'd1);
                if (seen >= s0 + 3) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        check("stream_started", 32'(ok), 32'd1);
        cmd_i = 2'b00;
        wait_drain("stream_drain");
        check("stream_count", 32'(frames_seen - f0), 32'd3);

        // Reset during bit 10, then a fresh pixel.
        f0 = frames_seen;
        r_i = 8'h12; g_i = 8'h34; b_i = 8'h56; cmd_i = 2'b01;
        tick();
        cmd_i = 2'b00;
        repeat (135) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mr_data", 32'(data_out_o), 32'd0);
        check("mr_req", 32'(cmd_req_o), 32'd1);
        check("mr_frames", 32'(frames_seen - f0), 32'd0);
        r_i = 8'hC3; g_i = 8'h3C; b_i = 8'h99; cmd_i = 2'b01;
        tick();
        cmd_i = 2'b00;
        wait_drain("mr_drain");
        check("mr_fresh", 32'(frames_seen - f0), 32'd1);

        // Inputs change mid-send; captured colour must be kept.
        f0 = frames_seen;
        r_i = 8'h81; g_i = 8'h7E; b_i = 8'h01; cmd_i = 2'b01;
        tick();
        cmd_i = 2'b11; r_i = 8'h00; g_i = 8'hFF; b_i = 8'hFF;
        repeat (50) tick();
        cmd_i = 2'b01; r_i = 8'hA5;
        repeat (100) tick();
        cmd_i = 2'b00;
        wait_drain("hold_drain");
        check("hold_count", 32'(frames_seen - f0), 32'd1);

        check("sb_final", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
